// File: rtl/sweep_controller.sv
// Triangle-sweep sequencer owning the count register and up/down mode flag.
// Optional turnaround dwell is built when SWEEP_DWELL_EN is defined.
module sweep_controller #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CYC_W   = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [CYC_W-1:0]   n_sweeps,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   count,
  output logic               mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYC_W-1:0]   sweeps_done
);

`ifdef SWEEP_DWELL_EN
  typedef enum logic [1:0] {StIdle, StUp, StDown, StDwell} state_e;
`else
  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;
`endif

  state_e             state;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [CYC_W-1:0]   n_q;
  logic [WIDTH-1:0]   cnt_inc, cnt_dec;
  logic [CYC_W-1:0]   sd_inc;
  logic               last_sweep;

`ifdef SWEEP_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
`else
  logic               unused_dwell;
  assign unused_dwell = ^dwell;
`endif

  assign cnt_inc    = count + WIDTH'(1);
  assign cnt_dec    = count - WIDTH'(1);
  assign sd_inc     = sweeps_done + CYC_W'(1);
  assign last_sweep = (n_q != '0) && (sd_inc == n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      count       <= '0;
      mode        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sweeps_done <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
`ifdef SWEEP_DWELL_EN
      dwell_q     <= '0;
      dwell_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          // start takes priority over abort here; abort is simply ignored in idle
          if (start) begin
            if (lo < hi) begin
              lo_q        <= lo;
              hi_q        <= hi;
              n_q         <= n_sweeps;
`ifdef SWEEP_DWELL_EN
              dwell_q     <= dwell;
`endif
              count       <= lo;
              mode        <= 1'b1;
              busy        <= 1'b1;
              sweeps_done <= '0;
              state       <= StUp;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StUp: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
            mode  <= 1'b1;
          end else begin
            count <= cnt_inc;
            if (cnt_inc == hi_q) begin
              mode  <= 1'b0;
              state <= StDown;
`ifdef SWEEP_DWELL_EN
              if (dwell_q != '0) begin
                state     <= StDwell;
                dwell_cnt <= dwell_q;
              end
`endif
            end
          end
        end
        StDown: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
            mode  <= 1'b1;
          end else begin
            count <= cnt_dec;
            if (cnt_dec == lo_q) begin
              sweeps_done <= sd_inc;
              mode        <= 1'b1;
              if (last_sweep) begin
                state <= StIdle;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= StUp;
`ifdef SWEEP_DWELL_EN
                if (dwell_q != '0) begin
                  state     <= StDwell;
                  dwell_cnt <= dwell_q;
                end
`endif
              end
            end
          end
        end
`ifdef SWEEP_DWELL_EN
        StDwell: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
            mode  <= 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
            // mode already points the way out of the turnaround
            if (dwell_cnt == DWELL_W'(1)) state <= mode ? StUp : StDown;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Directed self-checking bench for sweep_controller; covers the dwell build
// when SWEEP_DWELL_EN is defined.
module tb_sweep_controller;

  logic       clk, rst, start, abort;
  logic [7:0] lo, hi, count;
  logic [3:0] n_sweeps, dwell, sweeps_done;
  logic       mode, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  int c1[7] = '{2, 3, 4, 5, 4, 3, 2};
  int m1[7] = '{1, 1, 1, 0, 0, 0, 1};

  sweep_controller #(.WIDTH(8), .CYC_W(4), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .dwell(dwell), .count(count), .mode(mode), .busy(busy),
    .done(done), .err(err), .sweeps_done(sweeps_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks exp_q one cycle per entry; start/abort are dropped after the first edge.
  task automatic run_seq(input string tag, input bit fin);
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("%s count[%0d]", tag, i), count, exp_q[i]);
      check($sformatf("%s done[%0d]", tag, i), done, (fin && i == exp_q.size() - 1));
    end
    check({tag, " busy_end"}, busy, !fin);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " count"}, count, 0);
    check({tag, " mode"}, mode, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " sweeps"}, sweeps_done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0; dwell = '0;
    #2 rst = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // single sweep 2..5
    lo = 8'd2; hi = 8'd5; n_sweeps = 4'd1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
      check($sformatf("t1 count[%0d]", i), count, c1[i]);
      check($sformatf("t1 mode[%0d]", i), mode, m1[i]);
      check($sformatf("t1 busy[%0d]", i), busy, (i != 6));
      check($sformatf("t1 done[%0d]", i), done, (i == 6));
    end
    check("t1 sweeps", sweeps_done, 1);
    step();
    check("t1 done_drop", done, 0);

    // rejected starts
    lo = 8'd5; hi = 8'd5; start = 1'b1;
    step(); start = 1'b0;
    check("t2a err", err, 1);
    check("t2a busy", busy, 0);
    check("t2a count", count, 2);
    check("t2a sweeps", sweeps_done, 1);
    step();
    check("t2a err_drop", err, 0);
    lo = 8'd5; hi = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    check("t2b err", err, 1);
    check("t2b busy", busy, 0);
    check("t2b count", count, 2);
    step();
    check("t2b err_drop", err, 0);

    // continuous run, abort sampled on the 9th edge after start
    lo = 8'd0; hi = 8'd3; n_sweeps = 4'd0; start = 1'b1;
    exp_q = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
    run_seq("t3", 1'b0);
    abort = 1'b1;
    step(); abort = 1'b0;
    check("t3 ab busy", busy, 0);
    check("t3 ab count", count, 2);
    check("t3 ab sweeps", sweeps_done, 1);
    check("t3 ab done", done, 0);
    check("t3 ab mode", mode, 1);
    step();
    check("t3 hold count", count, 2);
    check("t3 hold done", done, 0);

    // start with abort in idle: start wins
    lo = 8'd0; hi = 8'd1; n_sweeps = 4'd1; start = 1'b1; abort = 1'b1;
    exp_q = '{0, 1, 0};
    run_seq("t3s", 1'b1);

    // top of range, ignored mid-run start and config change
    lo = 8'd250; hi = 8'd255; n_sweeps = 4'd2; start = 1'b1;
    step(); start = 1'b0;
    check("t4 count0", count, 250);
    for (int k = 1; k <= 20; k++) begin
      int p;
      if (k == 7) begin start = 1'b1; lo = 8'd0; hi = 8'd9; end
      step();
      start = 1'b0;
      p = k % 10;
      check($sformatf("t4 count[%0d]", k), count, (p <= 5) ? 250 + p : 260 - p);
      check($sformatf("t4 done[%0d]", k), done, (k == 20));
      if (k == 10) check("t4 sweeps_mid", sweeps_done, 1);
    end
    check("t4 sweeps", sweeps_done, 2);
    check("t4 busy", busy, 0);

    // async reset mid-DOWN at count 7
    lo = 8'd5; hi = 8'd9; n_sweeps = 4'd0; start = 1'b1;
    exp_q = '{5, 6, 7, 8, 9, 8, 7};
    run_seq("t5", 1'b0);
    check("t5 mode_down", mode, 0);
    #2 rst = 1'b1;
    #1 check_reset("t5 rst");
    @(negedge clk);
    rst = 1'b0;
    lo = 8'd1; hi = 8'd3; n_sweeps = 4'd1; start = 1'b1;
    exp_q = '{1, 2, 3, 2, 1};
    run_seq("t5b", 1'b1);
    check("t5b sweeps", sweeps_done, 1);

    lo = 8'd0; hi = 8'd2; n_sweeps = 4'd2; dwell = 4'd3; start = 1'b1;
`ifdef SWEEP_DWELL_EN
    exp_q = '{0, 1, 2, 2, 2, 2, 1, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0};
`else
    exp_q = '{0, 1, 2, 1, 0, 1, 2, 1, 0};
`endif
    run_seq("t6", 1'b1);
    check("t6 sweeps", sweeps_done, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
